csr_led_pwm: RTL and testbench

- CSR-mapped LED controller, the successor to the single-register CSR LED block.
- Generalised to WIDTH channels, with per-channel enable and per-channel blink, plus a global PWM brightness.
- Sits on the pipeline's CSR side bus; its rdata and valid are OR-ed into the core's csr_rdata and csr_valid.
- Drives board LEDs directly.

---
 rtl/csr_led_pwm_if.sv | 13 +
 rtl/csr_led_pwm.sv | 128 ++++++++++++
 tb/tb_csr_led_pwm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/csr_led_pwm_if.sv
// CSR side-bus bundle between the core pipeline and the LED/PWM block.
// The core drives the request fields; the block returns registered rdata/valid.
interface csr_led_pwm_if;
    logic        read;
    logic [1:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (output read, modify, wdata, addr, input rdata, valid);
    modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_led_pwm.sv
// CSR-mapped LED controller: per-channel enable and blink, global PWM brightness.
// Registers EN, BLINK and DUTY sit at BASE_ADDR..BASE_ADDR+2.
module csr_led_pwm #(
    parameter logic [11:0] BASE_ADDR     = 12'h7c1,
    parameter int unsigned WIDTH         = 18,
    parameter logic [31:0] RESET_PATTERN = 32'h81,
    parameter int unsigned PWM_BITS      = 4,
    parameter int unsigned PWM_PRESCALE  = 64,
    parameter int unsigned BLINK_DIV     = 12_500_000
) (
    input  logic              CLOCK_50,
    input  logic              rstn,
    csr_led_pwm_if.slave      bus,
    output logic [WIDTH-1:0]  leds,
    output logic              AVOID_WARNING
);
    localparam int unsigned DW     = PWM_BITS + 1;
    localparam int unsigned PS_W   = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int unsigned BL_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned USED_W = (WIDTH > DW) ? WIDTH : DW;
    localparam logic [63:0] USED_MASK   = (64'd1 << USED_W) - 64'd1;
    localparam logic [31:0] UNUSED_MASK = ~USED_MASK[31:0];
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_PRESCALE - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);
    localparam logic [DW-1:0]   DUTY_RST = {1'b1, {PWM_BITS{1'b0}}};

    logic [WIDTH-1:0]    en, blink;
    logic [DW-1:0]       duty;
    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BL_W-1:0]     blink_cnt;
    logic                phase;

    logic [WIDTH-1:0]    en_nxt, blink_nxt, leds_nxt;
    logic [DW-1:0]       duty_nxt;
    logic [PS_W-1:0]     presc_nxt;
    logic [PWM_BITS-1:0] pwm_cnt_nxt;
    logic [BL_W-1:0]     blink_cnt_nxt;
    logic                phase_nxt;
    logic                hit_en, hit_blink, hit_duty, hit_any;
    logic [31:0]         rdata_nxt;
    logic                pwm_on;

    function automatic logic [31:0] apply_mod(input logic [1:0]  m,
                                              input logic [31:0] cur,
                                              input logic [31:0] wd);
        logic [31:0] r;
        case (m)
            2'b01:   r = wd;
            2'b10:   r = cur | wd;
            2'b11:   r = cur & ~wd;
            default: r = cur;
        endcase
        return r;
    endfunction

    assign hit_en    = (bus.addr == BASE_ADDR);
    assign hit_blink = (bus.addr == BASE_ADDR + 12'd1);
    assign hit_duty  = (bus.addr == BASE_ADDR + 12'd2);
    assign hit_any   = hit_en | hit_blink | hit_duty;
    assign pwm_on    = ({1'b0, pwm_cnt} < duty);

    assign AVOID_WARNING = bus.read | (|(bus.wdata & UNUSED_MASK));

    // Register access: read returns the pre-modify value, modify lands at the same edge
    always_comb begin
        en_nxt    = en;
        blink_nxt = blink;
        duty_nxt  = duty;
        rdata_nxt = 32'd0;
        if (hit_en) begin
            rdata_nxt = 32'(en);
            en_nxt    = WIDTH'(apply_mod(bus.modify, 32'(en), bus.wdata));
        end
        if (hit_blink) begin
            rdata_nxt = 32'(blink);
            blink_nxt = WIDTH'(apply_mod(bus.modify, 32'(blink), bus.wdata));
        end
        if (hit_duty) begin
            rdata_nxt = 32'(duty);
            duty_nxt  = DW'(apply_mod(bus.modify, 32'(duty), bus.wdata));
        end
    end

    // Free-running PWM and blink timebases, untouched by CSR traffic
    always_comb begin
        presc_nxt     = presc + PS_W'(1);
        pwm_cnt_nxt   = pwm_cnt;
        blink_cnt_nxt = blink_cnt + BL_W'(1);
        phase_nxt     = phase;
        if (presc == PS_LAST) begin
            presc_nxt   = '0;
            pwm_cnt_nxt = pwm_cnt + PWM_BITS'(1);
        end
        if (blink_cnt == BL_LAST) begin
            blink_cnt_nxt = '0;
            phase_nxt     = ~phase;
        end
    end

    assign leds_nxt = en & {WIDTH{pwm_on}} & (~blink | {WIDTH{phase}});

    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            en        <= RESET_PATTERN[WIDTH-1:0];
            blink     <= '0;
            duty      <= DUTY_RST;
            presc     <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            leds      <= '0;
            bus.valid <= 1'b0;
            bus.rdata <= 32'd0;
        end else begin
            en        <= en_nxt;
            blink     <= blink_nxt;
            duty      <= duty_nxt;
            presc     <= presc_nxt;
            pwm_cnt   <= pwm_cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
            leds      <= leds_nxt;
            bus.valid <= hit_any;
            bus.rdata <= rdata_nxt;
        end
    end
endmodule

// File: tb/tb_csr_led_pwm.sv
// Scoreboard bench for csr_led_pwm: a cycle-count reference model predicts every edge,
// a separate monitor pops and compares valid/rdata/leds.
module tb_csr_led_pwm;
    localparam int unsigned WIDTH        = 18;
    localparam int unsigned PWM_BITS     = 4;
    localparam int unsigned PWM_PRESCALE = 1;
    localparam int unsigned BLINK_DIV    = 10;
    localparam int unsigned PERIOD       = 16;
    localparam logic [11:0] BASE      = 12'h7c1;
    localparam logic [11:0] IDLE_ADDR = 12'h000;
    localparam logic [31:0] RST_PAT   = 32'h81;
    localparam logic [31:0] EN_MASK   = 32'h0003_ffff;
    localparam logic [31:0] DUTY_MASK = 32'h0000_001f;

    typedef struct packed {
        logic             valid;
        logic [31:0]      rdata;
        logic [WIDTH-1:0] leds;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [WIDTH-1:0] leds;
    logic             aw;
    exp_t             q[$];
    int unsigned      checks = 0;
    int unsigned      failures = 0;
    int unsigned      total_on = 0;

    logic [31:0] m_en, m_blink, m_duty;
    int unsigned m_e;

    csr_led_pwm_if bus();

    csr_led_pwm #(
        .BASE_ADDR(BASE), .WIDTH(WIDTH), .RESET_PATTERN(RST_PAT),
        .PWM_BITS(PWM_BITS), .PWM_PRESCALE(PWM_PRESCALE), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .CLOCK_50(clk), .rstn(rstn), .bus(bus), .leds(leds), .AVOID_WARNING(aw)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, req, $time);
        end
    endfunction

    // Model: counters derived from edges since reset, registers from the access rules
    task automatic step(input logic r, input logic [1:0] m, input logic [11:0] a, input logic [31:0] wd);
        exp_t        x;
        int          idx;
        logic [31:0] old, nv, pmask, live;
        int unsigned pc;
        bit          ph;
        @(posedge clk);
        #2;
        rstn       = r;
        bus.modify = m;
        bus.addr   = a;
        bus.wdata  = wd;
        bus.read   = 1'($urandom_range(0, 1));
        x = '0;
        if (!r) begin
            m_en = RST_PAT & EN_MASK; m_blink = 0; m_duty = 32'd16; m_e = 0;
        end else begin
            m_e++;
            pc = ((m_e - 1) / PWM_PRESCALE) % PERIOD;
            ph = (((m_e - 1) / BLINK_DIV) % 2) == 0;
            live = ph ? m_en : (m_en & ~m_blink);
            if (pc < m_duty) x.leds = WIDTH'(live);
            idx = int'(a) - int'(BASE);
            if (idx >= 0 && idx <= 2) begin
                old   = (idx == 0) ? m_en : (idx == 1) ? m_blink : m_duty;
                pmask = (idx == 2) ? DUTY_MASK : EN_MASK;
                x.valid = 1'b1;
                x.rdata = old;
                case (m)
                    2'b01:   nv = wd & pmask;
                    2'b10:   nv = (old | wd) & pmask;
                    2'b11:   nv = old & ~wd & pmask;
                    default: nv = old;
                endcase
                if (idx == 0) m_en = nv;
                else if (idx == 1) m_blink = nv;
                else m_duty = nv;
            end
        end
        q.push_back(x);
        #1;
        cmp("avoid_warning", 32'(aw), 32'(bus.read | (|wd[31:WIDTH])));
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) step(1'b1, 2'b00, IDLE_ADDR, 32'd0);
    endtask

    // leds[0] high count over one full PWM period after a DUTY write
    task automatic measure(input logic [31:0] d, input int unsigned want);
        int unsigned s;
        step(1'b1, 2'b01, BASE + 12'd2, d);
        idle(1);
        s = total_on;
        idle(PERIOD);
        cmp("duty_on_count", total_on - s, want);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (leds[0]) total_on++;
            if (q.size() != 0) begin
                x = q.pop_front();
                cmp("valid", 32'(bus.valid), 32'(x.valid));
                cmp("rdata", bus.rdata, x.rdata);
                cmp("leds", 32'(leds), 32'(x.leds));
            end
        end
    end

    initial begin : stimulus
        logic [11:0] a;
        logic [31:0] wd;
        logic        r;
        rstn = 1'b0; bus.read = 1'b0; bus.modify = 2'b00; bus.addr = IDLE_ADDR; bus.wdata = 32'd0;
        m_en = 0; m_blink = 0; m_duty = 0; m_e = 0;

        step(1'b0, 2'b00, IDLE_ADDR, 32'd0);
        step(1'b0, 2'b00, IDLE_ADDR, 32'd0);
        step(1'b1, 2'b00, BASE, 32'd0);
        idle(4);

        step(1'b1, 2'b01, BASE, 32'h3);
        step(1'b1, 2'b10, BASE, 32'h30);
        step(1'b1, 2'b11, BASE, 32'h1);
        step(1'b1, 2'b00, BASE, 32'd0);
        idle(3);

        step(1'b1, 2'b01, BASE, 32'h1);
        measure(32'd4, 4);
        measure(32'd0, 0);
        measure(32'd16, 16);
        measure(32'd31, 16);

        step(1'b1, 2'b01, BASE + 12'd2, 32'd16);
        step(1'b1, 2'b01, BASE, 32'h3);
        step(1'b1, 2'b01, BASE + 12'd1, 32'h1);
        idle(25);
        step(1'b1, 2'b11, BASE + 12'd1, 32'h1);
        idle(12);

        step(1'b1, 2'b01, BASE + 12'd3, 32'hffff_ffff);
        step(1'b1, 2'b01, BASE - 12'd1, 32'hffff_ffff);
        step(1'b1, 2'b00, BASE, 32'd0);
        step(1'b1, 2'b00, BASE + 12'd1, 32'd0);
        step(1'b1, 2'b00, BASE + 12'd2, 32'd0);

        step(1'b1, 2'b01, BASE + 12'd1, 32'h5);
        step(1'b1, 2'b01, BASE + 12'd2, 32'd4);
        idle(7);
        step(1'b0, 2'b01, BASE, 32'hffff_ffff);
        step(1'b1, 2'b00, BASE, 32'd0);
        step(1'b1, 2'b00, BASE + 12'd1, 32'd0);
        step(1'b1, 2'b00, BASE + 12'd2, 32'd0);
        idle(5);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 12'd1;
                1:       a = BASE + 12'd3;
                2:       a = 12'($urandom);
                default: a = BASE + 12'($urandom_range(0, 2));
            endcase
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) wd = wd & 32'h1f;
            r = ($urandom_range(0, 63) != 0);
            step(r, 2'($urandom_range(0, 3)), a, wd);
        end

        @(posedge clk);
        #3;
        cmp("queue_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
